// File: rtl/operand_issue_stage.sv
// operand_issue_stage
//   Registered, stallable operand stage between the IF/ID register and EX.
//   Holds the architectural register file (x0 hardwired to zero, write-through
//   from writeback), resolves rs1/rs2 through NUM_FWD ranked forwarding ports
//   (port 0 youngest), tracks in-flight destinations with a per-register
//   counter scoreboard, and presents the issued instruction on a valid/ready
//   output register that can be flushed.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   in_*                          upstream instruction and handshake (in_ready)
//   fwd_valid/data_ok/rd/data     forwarding ports, port i in slice i
//   wb_we/rd/data                 register-file write
//   rel_valid/rel_rd              scoreboard release
//   flush                         drop output entry and current input
//   out_*                         EX-side output register and handshake
//   hazard_stall                  input valid but blocked by an operand hazard
module operand_issue_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_FWD  = 2,
  parameter int unsigned CNT_W    = 2,
  localparam int unsigned RW      = $clog2(NUM_REGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_pc,
  input  logic [XLEN-1:0]         in_imm,
  input  logic [RW-1:0]           in_rs1,
  input  logic [RW-1:0]           in_rs2,
  input  logic [RW-1:0]           in_rd,
  input  logic                    in_uses_rs1,
  input  logic                    in_uses_rs2,
  input  logic                    in_writes_rd,
  input  logic                    in_a_sel,
  input  logic                    in_b_sel,
  input  logic [NUM_FWD-1:0]      fwd_valid,
  input  logic [NUM_FWD-1:0]      fwd_data_ok,
  input  logic [NUM_FWD*RW-1:0]   fwd_rd,
  input  logic [NUM_FWD*XLEN-1:0] fwd_data,
  input  logic                    wb_we,
  input  logic [RW-1:0]           wb_rd,
  input  logic [XLEN-1:0]         wb_data,
  input  logic                    rel_valid,
  input  logic [RW-1:0]           rel_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [XLEN-1:0]         out_imm,
  output logic [XLEN-1:0]         out_rs1_data,
  output logic [XLEN-1:0]         out_rs2_data,
  output logic [XLEN-1:0]         out_op_a,
  output logic [XLEN-1:0]         out_op_b,
  output logic [RW-1:0]           out_rd,
  output logic                    out_writes_rd,
  output logic                    hazard_stall
);

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [XLEN-1:0]  rf_q  [NUM_REGS];
  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] cnt_d [NUM_REGS];

  logic [RW-1:0]   src_idx [2];
  logic            src_use [2];
  logic [XLEN-1:0] src_val [2];
  logic            src_rdy [2];
  logic            src_hit [2];

  logic hazard;
  logic fire;

  // Operand resolution: forwarding beats write-through beats register file.
  always_comb begin
    src_idx[0] = in_rs1;
    src_idx[1] = in_rs2;
    src_use[0] = in_uses_rs1;
    src_use[1] = in_uses_rs2;
    for (int s = 0; s < 2; s++) begin
      src_val[s] = '0;
      src_rdy[s] = 1'b1;
      src_hit[s] = 1'b0;
      if (src_use[s] && src_idx[s] != '0) begin
        // Walk from oldest to youngest so the lowest matching port wins.
        for (int i = int'(NUM_FWD) - 1; i >= 0; i--) begin
          if (fwd_valid[i] && fwd_rd[i*RW +: RW] == src_idx[s]) begin
            src_hit[s] = 1'b1;
            src_val[s] = fwd_data[i*XLEN +: XLEN];
            src_rdy[s] = fwd_data_ok[i];
          end
        end
        if (!src_hit[s]) begin
          if (wb_we && wb_rd == src_idx[s]) begin
            src_val[s] = wb_data;
          end else begin
            src_val[s] = rf_q[src_idx[s]];
            src_rdy[s] = (cnt_q[src_idx[s]] == '0);
          end
        end
      end
    end
  end

  always_comb begin
    hazard = !src_rdy[0] || !src_rdy[1] ||
             (in_writes_rd && in_rd != '0 && cnt_q[in_rd] == CntMax);
    fire = !rst && in_valid && !hazard && !flush && (!out_valid || out_ready);
    in_ready = fire;
    hazard_stall = !rst && in_valid && hazard && !flush;
  end

  // Scoreboard next state: +1 on issue, -1 per release source, floored at 0.
  always_comb begin
    for (int r = 0; r < int'(NUM_REGS); r++) begin
      int tmp;
      tmp = int'(cnt_q[r]);
      if (r != 0) begin
        if (fire && in_writes_rd && in_rd == RW'(r)) tmp = tmp + 1;
        if (rel_valid && rel_rd == RW'(r)) tmp = tmp - 1;
        if (flush && out_valid && out_writes_rd && out_rd == RW'(r)) tmp = tmp - 1;
      end
      if (tmp < 0) tmp = 0;
      cnt_d[r] = CNT_W'(tmp);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        rf_q[r]  <= '0;
        cnt_q[r] <= '0;
      end
    end else begin
      for (int r = 0; r < int'(NUM_REGS); r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      if (wb_we && wb_rd != '0) begin
        rf_q[wb_rd] <= wb_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_imm       <= '0;
      out_rs1_data  <= '0;
      out_rs2_data  <= '0;
      out_op_a      <= '0;
      out_op_b      <= '0;
      out_rd        <= '0;
      out_writes_rd <= 1'b0;
    end else if (fire) begin
      out_valid     <= 1'b1;
      out_pc        <= in_pc;
      out_imm       <= in_imm;
      out_rs1_data  <= src_val[0];
      out_rs2_data  <= src_val[1];
      out_op_a      <= in_a_sel ? in_pc : src_val[0];
      out_op_b      <= in_b_sel ? in_imm : src_val[1];
      out_rd        <= in_rd;
      out_writes_rd <= in_writes_rd;
    end else if (flush || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_operand_issue_stage.sv
module tb_operand_issue_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned NUM_FWD = 2;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready;
  logic [XLEN-1:0] in_pc, in_imm;
  logic [RW-1:0] in_rs1, in_rs2, in_rd;
  logic in_uses_rs1, in_uses_rs2, in_writes_rd, in_a_sel, in_b_sel;
  logic [NUM_FWD-1:0] fwd_valid, fwd_data_ok;
  logic [NUM_FWD*RW-1:0] fwd_rd;
  logic [NUM_FWD*XLEN-1:0] fwd_data;
  logic wb_we;
  logic [RW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;
  logic rel_valid;
  logic [RW-1:0] rel_rd;
  logic flush;
  logic out_valid, out_ready;
  logic [XLEN-1:0] out_pc, out_imm, out_rs1_data, out_rs2_data, out_op_a, out_op_b;
  logic [RW-1:0] out_rd;
  logic out_writes_rd, hazard_stall;

  int n_checks;
  int n_fail;

  operand_issue_stage #(
    .XLEN(XLEN), .NUM_REGS(NUM_REGS), .NUM_FWD(NUM_FWD), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
    .in_a_sel(in_a_sel), .in_b_sel(in_b_sel),
    .fwd_valid(fwd_valid), .fwd_data_ok(fwd_data_ok), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .rel_valid(rel_valid), .rel_rd(rel_rd), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_rs1_data(out_rs1_data),
    .out_rs2_data(out_rs2_data), .out_op_a(out_op_a), .out_op_b(out_op_b),
    .out_rd(out_rd), .out_writes_rd(out_writes_rd), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        u1, u2, asel, bsel;
    logic [31:0] pc, imm;
    logic [1:0]  fv, fok;
    logic [4:0]  frd0, frd1;
    logic [31:0] fd0, fd1;
    logic        wbe;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        exp_ready;
    logic [31:0] e_rs1, e_rs2, e_a, e_b;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    in_valid = 1'b0; in_pc = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0;
    in_uses_rs1 = 1'b0; in_uses_rs2 = 1'b0; in_writes_rd = 1'b0;
    in_a_sel = 1'b0; in_b_sel = 1'b0;
    fwd_valid = '0; fwd_data_ok = '0; fwd_rd = '0; fwd_data = '0;
    wb_we = 1'b0; wb_rd = '0; wb_data = '0;
    rel_valid = 1'b0; rel_rd = '0; flush = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    // rs1 rs2 u1 u2 asel bsel pc imm | fv fok frd0 frd1 fd0 fd1 | wbe wbrd wbd | rdy rs1 rs2 a b
    vecs[0] = '{5'd5, 5'd0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10, 32'h4,
                2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h1234, 32'h0, 32'h1234, 32'h0};
    vecs[1] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 32'h100, 32'h44,
                2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h1234, 32'h5678, 32'h100, 32'h44};
    vecs[2] = '{5'd5, 5'd6, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0,
                2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h0, 32'h5678, 32'h0, 32'h5678};
    vecs[3] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h24, 32'h0,
                2'b10, 2'b10, 5'd0, 5'd5, 32'h0, 32'h11, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h11, 32'h5678, 32'h11, 32'h5678};
    vecs[4] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h28, 32'h0,
                2'b11, 2'b11, 5'd5, 5'd5, 32'h22, 32'h11, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h22, 32'h5678, 32'h22, 32'h5678};
    vecs[5] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h2c, 32'h0,
                2'b11, 2'b10, 5'd5, 5'd5, 32'h22, 32'h11, 1'b0, 5'd0, 32'h0,
                1'b0, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6] = '{5'd5, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0,
                2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd7, 32'hAAAA,
                1'b1, 32'h1234, 32'hAAAA, 32'h1234, 32'hAAAA};
    vecs[7] = '{5'd0, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, 32'h34, 32'h0,
                2'b01, 2'b01, 5'd0, 5'd0, 32'h99, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h0, 32'h5678, 32'h0, 32'h5678};
    vecs[8] = '{5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 32'h38, 32'h0,
                2'b01, 2'b00, 5'd6, 5'd0, 32'h33, 32'h0, 1'b0, 5'd0, 32'h0,
                1'b1, 32'h1234, 32'h0, 32'h1234, 32'h0};
    vecs[9] = '{5'd5, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1, 32'h3c, 32'h8,
                2'b10, 2'b10, 5'd0, 5'd6, 32'h0, 32'h77, 1'b1, 5'd6, 32'hDEAD,
                1'b1, 32'h1234, 32'h77, 32'h1234, 32'h8};

    // Reset with a valid instruction presented: nothing may be accepted.
    clear_inputs();
    out_ready = 1'b1;
    rst = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd5; in_uses_rs1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_rs1", out_rs1_data, 32'h0);
    chk("rst_hazard", {31'b0, hazard_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    wb_we = 1'b1; wb_rd = 5'd5; wb_data = 32'h1234;
    @(negedge clk);
    wb_rd = 5'd6; wb_data = 32'h5678;
    @(negedge clk);
    wb_we = 1'b0;

    for (int i = 0; i < 10; i++) begin
      clear_inputs();
      in_valid = 1'b1;
      in_rs1 = vecs[i].rs1; in_rs2 = vecs[i].rs2;
      in_uses_rs1 = vecs[i].u1; in_uses_rs2 = vecs[i].u2;
      in_a_sel = vecs[i].asel; in_b_sel = vecs[i].bsel;
      in_pc = vecs[i].pc; in_imm = vecs[i].imm;
      fwd_valid = vecs[i].fv; fwd_data_ok = vecs[i].fok;
      fwd_rd = {vecs[i].frd1, vecs[i].frd0};
      fwd_data = {vecs[i].fd1, vecs[i].fd0};
      wb_we = vecs[i].wbe; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, {31'b0, vecs[i].exp_ready});
      chk($sformatf("v%0d_stall", i), {31'b0, hazard_stall}, {31'b0, !vecs[i].exp_ready});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ready});
      if (vecs[i].exp_ready) begin
        chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
        chk($sformatf("v%0d_rs1", i), out_rs1_data, vecs[i].e_rs1);
        chk($sformatf("v%0d_rs2", i), out_rs2_data, vecs[i].e_rs2);
        chk($sformatf("v%0d_op_a", i), out_op_a, vecs[i].e_a);
        chk($sformatf("v%0d_op_b", i), out_op_b, vecs[i].e_b);
      end
      @(negedge clk);
    end

    // RAW hazard on x3, released one cycle before the reader may issue.
    clear_inputs();
    in_valid = 1'b1; in_writes_rd = 1'b1; in_rd = 5'd3;
    #1;
    chk("w3_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    clear_inputs();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hBEEF;
    @(negedge clk);
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd3; in_uses_rs1 = 1'b1; in_pc = 32'h80;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("raw_stall", {31'b0, hazard_stall}, 32'h1);
      chk("raw_in_ready", {31'b0, in_ready}, 32'h0);
      @(negedge clk);
    end
    rel_valid = 1'b1; rel_rd = 5'd3;
    #1;
    chk("raw_rel_same_cycle", {31'b0, hazard_stall}, 32'h1);
    @(negedge clk);
    rel_valid = 1'b0;
    #1;
    chk("raw_after_rel", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("raw_out_valid", {31'b0, out_valid}, 32'h1);
    chk("raw_rs1", out_rs1_data, 32'hBEEF);
    @(negedge clk);

    // Backpressure: output held, input blocked, then captured on release.
    clear_inputs();
    @(negedge clk);
    in_valid = 1'b1; in_pc = 32'h200;
    @(negedge clk);
    out_ready = 1'b0; in_pc = 32'h300;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
      chk("bp_stall", {31'b0, hazard_stall}, 32'h0);
      chk("bp_out_valid", {31'b0, out_valid}, 32'h1);
      chk("bp_out_pc", out_pc, 32'h200);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("bp_next_pc", out_pc, 32'h300);
    chk("bp_next_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);

    // Flush drops the x7 writer and its scoreboard entry.
    clear_inputs();
    in_valid = 1'b1; in_writes_rd = 1'b1; in_rd = 5'd7; in_pc = 32'h400;
    @(negedge clk);
    clear_inputs();
    out_ready = 1'b0; flush = 1'b1;
    in_valid = 1'b1; in_rs1 = 5'd7; in_uses_rs1 = 1'b1; in_pc = 32'h404;
    #1;
    chk("fl_in_ready", {31'b0, in_ready}, 32'h0);
    chk("fl_stall", {31'b0, hazard_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("fl_out_valid", {31'b0, out_valid}, 32'h0);
    @(negedge clk);
    flush = 1'b0; out_ready = 1'b1;
    #1;
    chk("fl_reader_ready", {31'b0, in_ready}, 32'h1);
    chk("fl_reader_stall", {31'b0, hazard_stall}, 32'h0);
    @(posedge clk);
    #1;
    chk("fl_reader_rs1", out_rs1_data, 32'hAAAA);
    @(negedge clk);

    // Scoreboard saturation on x9 with a 2-bit counter.
    clear_inputs();
    in_valid = 1'b1; in_writes_rd = 1'b1; in_rd = 5'd9;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("sat_issue", {31'b0, in_ready}, 32'h1);
      @(negedge clk);
    end
    #1;
    chk("sat_full_stall", {31'b0, hazard_stall}, 32'h1);
    chk("sat_full_ready", {31'b0, in_ready}, 32'h0);
    rel_valid = 1'b1; rel_rd = 5'd9;
    #1;
    chk("sat_rel_same_cycle", {31'b0, hazard_stall}, 32'h1);
    @(negedge clk);
    rel_valid = 1'b0;
    #1;
    chk("sat_after_rel", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    #1;
    chk("sat_full_again", {31'b0, hazard_stall}, 32'h1);

    // Reset while stalled: counters and register file cleared.
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'h0);
    chk("mrst_stall", {31'b0, hazard_stall}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    in_valid = 1'b1; in_rs1 = 5'd9; in_uses_rs1 = 1'b1; in_rs2 = 5'd5; in_uses_rs2 = 1'b1;
    #1;
    chk("mrst_reader_ready", {31'b0, in_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("mrst_out_valid2", {31'b0, out_valid}, 32'h1);
    chk("mrst_rs2_cleared", out_rs2_data, 32'h0);
    @(negedge clk);
    clear_inputs();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
